// File: rtl/mac_row_sequencer.sv
// Row-at-a-time sequencer for the N-PE MAC array and A/B operand regfile.
// All outputs are registered from the next-state decode.
module mac_row_sequencer #(
  parameter int N    = 16,
  parameter int LogN = $clog2(N),
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic [LogN-1:0] seq_a,
  output logic [LogN-1:0] seq_b,
  output logic            matab_mux,
  output logic [N-1:0]    mac_ctrl,
  output logic [N-1:0]    rst_mul,
  output logic [N-1:0]    write_mat,
  output logic [LogN-1:0] row_idx,
  output logic            row_valid
);

  // state   | meaning
  // S_IDLE  | waiting for start, all outputs low
  // S_CLEAR | clear PE accumulators for row r
  // S_MAC   | operand fetch (phase 0 = A, phase 1 = B + MAC enable) for k
  // S_DRAIN | wait LAT cycles for the PE pipeline
  // S_WRITE | commit row r
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [LogN-1:0] LAST       = LogN'(N - 1);
  localparam logic [2:0]      DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t          state, nxt_state;
  logic [LogN-1:0] r, nxt_r, k, nxt_k;
  logic            phase, nxt_phase;
  logic [2:0]      drain_cnt, nxt_drain;
  logic            frozen;

  logic            nxt_busy, nxt_done, nxt_mux, nxt_row_valid;
  logic [LogN-1:0] nxt_seq_a, nxt_seq_b;
  logic [N-1:0]    nxt_mac, nxt_rst_mul, nxt_write;

  always_comb begin
    nxt_state = state;
    nxt_r     = r;
    nxt_k     = k;
    nxt_phase = phase;
    nxt_drain = drain_cnt;
    frozen    = 1'b0;
    if (state == S_IDLE) begin
      if (start) begin
        nxt_state = S_CLEAR;
        nxt_r     = '0;
      end
    end else if (abort) begin
      nxt_state = S_IDLE;
      nxt_r     = '0;
      nxt_k     = '0;
      nxt_phase = 1'b0;
      nxt_drain = '0;
    end else if (stall && state != S_DONE) begin
      frozen = 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          nxt_state = S_MAC;
          nxt_k     = '0;
          nxt_phase = 1'b0;
        end
        S_MAC: begin
          if (!phase) begin
            nxt_phase = 1'b1;
          end else if (k == LAST) begin
            nxt_phase = 1'b0;
            if (LAT == 0) begin
              nxt_state = S_WRITE;
            end else begin
              nxt_state = S_DRAIN;
              nxt_drain = DRAIN_INIT;
            end
          end else begin
            nxt_k     = k + 1'b1;
            nxt_phase = 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'd0) nxt_state = S_WRITE;
          else                   nxt_drain = drain_cnt - 3'd1;
        end
        S_WRITE: begin
          if (r == LAST) begin
            nxt_state = S_DONE;
          end else begin
            nxt_r     = r + 1'b1;
            nxt_state = S_CLEAR;
          end
        end
        S_DONE: begin
          nxt_state = S_IDLE;
          nxt_r     = '0;
          nxt_k     = '0;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Operand indices only move on a live MAC cycle; they hold through stalls and other states.
  always_comb begin
    nxt_busy      = (nxt_state != S_IDLE);
    nxt_done      = (nxt_state == S_DONE);
    nxt_rst_mul   = (!frozen && nxt_state == S_CLEAR) ? '1 : '0;
    nxt_mac       = (!frozen && nxt_state == S_MAC && nxt_phase) ? '1 : '0;
    nxt_write     = (!frozen && nxt_state == S_WRITE) ? '1 : '0;
    nxt_row_valid = !frozen && (nxt_state == S_WRITE);
    nxt_seq_a     = seq_a;
    nxt_seq_b     = seq_b;
    nxt_mux       = matab_mux;
    if (nxt_state == S_IDLE) begin
      nxt_seq_a = '0;
      nxt_seq_b = '0;
      nxt_mux   = 1'b0;
    end else if (!frozen && nxt_state == S_MAC) begin
      nxt_seq_a = nxt_r;
      nxt_seq_b = nxt_k;
      nxt_mux   = nxt_phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      r         <= '0;
      k         <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_a     <= '0;
      seq_b     <= '0;
      matab_mux <= 1'b0;
      mac_ctrl  <= '0;
      rst_mul   <= '0;
      write_mat <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
    end else begin
      state     <= nxt_state;
      r         <= nxt_r;
      k         <= nxt_k;
      phase     <= nxt_phase;
      drain_cnt <= nxt_drain;
      busy      <= nxt_busy;
      done      <= nxt_done;
      seq_a     <= nxt_seq_a;
      seq_b     <= nxt_seq_b;
      matab_mux <= nxt_mux;
      mac_ctrl  <= nxt_mac;
      rst_mul   <= nxt_rst_mul;
      write_mat <= nxt_write;
      row_idx   <= nxt_r;
      row_valid <= nxt_row_valid;
    end
  end

endmodule

// File: tb/tb_mac_row_sequencer.sv
// Bench for mac_row_sequencer: N=4 with LAT=2 and LAT=0 side by side, checked
// cycle by cycle against a job-schedule reference model.
module tb_mac_row_sequencer;

  localparam int NB = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] seq_a;
    logic [1:0] seq_b;
    logic       mux;
    logic [3:0] mac;
    logic [3:0] rst;
    logic [3:0] wr;
    logic [1:0] row;
    logic       rv;
  } out_t;

  logic clk, rst_n, start, abort, stall;

  logic       busy0, done0, mux0, rv0, busy1, done1, mux1, rv1;
  logic [1:0] sa0, sb0, row0, sa1, sb1, row1;
  logic [3:0] mac0, rm0, wr0, mac1, rm1, wr1;

  out_t got [2];
  assign got[0] = {busy0, done0, sa0, sb0, mux0, mac0, rm0, wr0, row0, rv0};
  assign got[1] = {busy1, done1, sa1, sb1, mux1, mac1, rm1, wr1, row1, rv1};

  mac_row_sequencer #(.N(NB), .LAT(2)) u_dut_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .busy(busy0), .done(done0), .seq_a(sa0), .seq_b(sb0), .matab_mux(mux0),
    .mac_ctrl(mac0), .rst_mul(rm0), .write_mat(wr0), .row_idx(row0), .row_valid(rv0)
  );

  mac_row_sequencer #(.N(NB), .LAT(0)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .busy(busy1), .done(done1), .seq_a(sa1), .seq_b(sb1), .matab_mux(mux1),
    .mac_ctrl(mac1), .rst_mul(rm1), .write_mat(wr1), .row_idx(row1), .row_valid(rv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  int dn_cnt [2];
  int dn1 [2];
  int dn2 [2];
  int mac_cnt;

  int   lats [2] = '{2, 0};
  bit   m_act [2];
  int   m_p [2];
  out_t m_out [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int job_len(int lat);
    return NB * (2 * NB + lat + 2) + 1;
  endfunction

  // Output of job-schedule slot p; non-MAC slots keep the previous operand indices.
  function automatic out_t entry(int lat, int p, out_t prev);
    out_t o;
    int rl, row, off, kk, ph;
    rl = 2 * NB + lat + 2;
    o = '0;
    o.busy  = 1'b1;
    o.seq_a = prev.seq_a;
    o.seq_b = prev.seq_b;
    o.mux   = prev.mux;
    if (p == job_len(lat) - 1) begin
      o.done = 1'b1;
      o.row  = 2'(NB - 1);
      return o;
    end
    row = p / rl;
    off = p % rl;
    o.row = 2'(row);
    if (off == 0) begin
      o.rst = '1;
    end else if (off <= 2 * NB) begin
      kk = (off - 1) / 2;
      ph = (off - 1) % 2;
      o.seq_a = 2'(row);
      o.seq_b = 2'(kk);
      o.mux   = (ph == 1);
      if (ph == 1) o.mac = '1;
    end else if (off == rl - 1) begin
      o.wr = '1;
      o.rv = 1'b1;
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      m_p[d]   = 0;
      m_out[d] = '0;
    end
  endtask

  task automatic model_step(int d);
    out_t o;
    if (!m_act[d]) begin
      if (start) begin
        m_act[d] = 1'b1;
        m_p[d]   = 0;
        m_out[d] = entry(lats[d], 0, '0);
      end else begin
        m_out[d] = '0;
      end
    end else if (abort) begin
      m_act[d] = 1'b0;
      m_out[d] = '0;
    end else if (stall && m_p[d] != job_len(lats[d]) - 1) begin
      o = m_out[d];
      o.done = 1'b0;
      o.mac  = '0;
      o.rst  = '0;
      o.wr   = '0;
      o.rv   = 1'b0;
      m_out[d] = o;
    end else if (m_p[d] == job_len(lats[d]) - 1) begin
      m_act[d] = 1'b0;
      m_out[d] = '0;
    end else begin
      m_p[d]++;
      m_out[d] = entry(lats[d], m_p[d], m_out[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cyc%0d_dut%0d", cyc, d), 32'(got[d]), 32'(m_out[d]));
      if (got[d].done) begin
        if (dn_cnt[d] == 0) dn1[d] = cyc;
        else if (dn_cnt[d] == 1) dn2[d] = cyc;
        dn_cnt[d]++;
      end
    end
    if (got[0].mac != 4'h0) mac_cnt++;
  endtask

  // Inputs "at cycle x" are high during cycle x and sampled on edge x+1.
  task automatic run(int ncyc, bit do_start, int stall_at, int stall_len,
                     int abort_at, bit repulse, bit hold);
    cyc = 0;
    mac_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      dn_cnt[d] = 0;
      dn1[d] = 0;
      dn2[d] = 0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      start = (do_start && c == 1) || hold || (repulse && (c == 11 || c == 31));
      stall = (stall_len > 0) && (c > stall_at + 1 - 1) && (c > stall_at) && (c <= stall_at + stall_len);
      abort = (c == abort_at + 1);
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    model_reset();
    #7;
    chk("reset_lat2", 32'(got[0]), 32'd0);
    chk("reset_lat0", 32'(got[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(60, 1'b1, 0, 0, -1, 1'b0, 1'b0);
    chk("plain_done_cycle", dn1[0], 49);
    chk("plain_done_count", dn_cnt[0], 1);
    chk("lat0_done_cycle", dn1[1], 41);

    run(60, 1'b1, 5, 3, -1, 1'b0, 1'b0);
    chk("stall_done_cycle", dn1[0], 52);
    chk("stall_lat0_done_cycle", dn1[1], 44);
    chk("stall_mac_pulses", mac_cnt, 4 * NB);

    run(20, 1'b1, 0, 0, 20, 1'b0, 1'b0);
    run(1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("abort_idle_lat2", 32'(got[0]), 32'd0);
    chk("abort_idle_lat0", 32'(got[1]), 32'd0);
    chk("abort_no_done", dn_cnt[0], 0);
    run(60, 1'b1, 0, 0, -1, 1'b0, 1'b0);
    chk("after_abort_done", dn1[0], 49);

    run(60, 1'b1, 0, 0, -1, 1'b1, 1'b0);
    chk("repulse_done_count", dn_cnt[0], 1);
    chk("repulse_done_cycle", dn1[0], 49);

    run(100, 1'b1, 0, 0, -1, 1'b0, 1'b1);
    chk("hold_done1", dn1[0], 49);
    chk("hold_done2", dn2[0], 99);
    chk("hold_lat0_done2", dn2[1], 83);
    run(60, 1'b0, 0, 0, -1, 1'b0, 1'b0);

    run(12, 1'b1, 0, 0, -1, 1'b0, 1'b0);
    chk("write_row_valid", 32'(got[0].rv), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lat2", 32'(got[0]), 32'd0);
    chk("async_rst_lat0", 32'(got[1]), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    run(40, 1'b0, 0, 0, -1, 1'b0, 1'b0);
    chk("post_rst_no_done", dn_cnt[0] + dn_cnt[1], 0);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      stall = ($urandom % 5) == 0;
      abort = ($urandom % 60) == 0;
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    run(80, 1'b0, 0, 0, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
